// File: rtl/bcd7seg_pkg.sv
// bcd7seg_pkg
// Shared types and constants for the five-digit multiplexed seven-segment
// driver: digit count, BCD digit / segment vector types, and the active-high
// segment patterns (bit order gfedcba, seg[0]=a .. seg[6]=g).
// Optional feature macro used by the driver: BCD7SEG_LZB_EN (leading-zero
// blanking).
package bcd7seg_pkg;

  localparam int NUM_DIGITS = 5;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd7seg_dec.sv
// bcd7seg_dec
// Combinational BCD to seven-segment decoder, active-high output.
// Codes 10..15 decode to blank. Polarity is handled by the parent.
// Ports:
//   digit_i : 4-bit BCD digit
//   seg_o   : 7-bit segment pattern, seg_o[0]=a .. seg_o[6]=g
module bcd7seg_dec
  import bcd7seg_pkg::*;
(
  input  bcd_t digit_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd7seg_scan5.sv
// bcd7seg_scan5
// Five-digit multiplexed seven-segment driver. Captures the converter's BCD
// result into shadow registers on `load`, scans one digit per DIV cycles,
// and pulses `req` once per frame (when the converter is idle) to start the
// next conversion.
// Optional feature: define BCD7SEG_LZB_EN to blank leading zeros (digit 0 is
// never blanked). Without it, every digit is displayed.
// Ports:
//   CLK       : clock, rising edge
//   RST       : asynchronous active-high reset
//   load      : captures bcd0..bcd4 (connect to converter fin)
//   bcd0..4   : BCD digits, bcd0 least significant
//   conv_busy : converter busy
//   req       : one-cycle conversion request (connect to converter en)
//   seg       : segments a..g on seg[0]..seg[6], registered, polarity per SEG_ACTIVE_LOW
//   an        : digit enables, an[k] = digit k, registered, polarity per AN_ACTIVE_LOW
module bcd7seg_scan5
  import bcd7seg_pkg::*;
#(
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic       conv_busy,
  output logic       req,
  output logic [6:0] seg,
  output logic [4:0] an
);

  localparam int             PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  // XOR masks turn the active-high internal values into pin polarity; the
  // same mask is the "all off" level used at reset.
  localparam seg_t       SEG_XOR = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [4:0] AN_XOR  = AN_ACTIVE_LOW  ? 5'h1F : 5'h00;

  bcd_t             bcd_in [NUM_DIGITS];
  bcd_t             dig_q  [NUM_DIGITS];
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d, sel;
  logic             tick;
  logic             req_q, req_d;
  seg_t             seg_q, seg_d;
  logic [4:0]       an_q, an_d;
  bcd_t             dig_sel;
  seg_t             dec_seg;
  logic             blank_sel;

  assign bcd_in[0] = bcd0;
  assign bcd_in[1] = bcd1;
  assign bcd_in[2] = bcd2;
  assign bcd_in[3] = bcd3;
  assign bcd_in[4] = bcd4;

  // Shadow registers: all digits update together on load.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        dig_q[gi] <= '0;
      end else if (load) begin
        dig_q[gi] <= bcd_in[gi];
      end
    end
  end

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    // Out-of-range indices (5..7) collapse to 0 whether or not a tick occurs.
    if (tick) begin
      idx_d = (idx_q >= 3'd4) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = (idx_q > 3'd4) ? 3'd0 : idx_q;
    end
    // Request is dropped, not deferred, if the converter is busy at frame end.
    req_d = (idx_q == 3'd4) && tick && !conv_busy;
  end

  always_comb begin
    sel = (idx_q > 3'd4) ? 3'd0 : idx_q;
    dig_sel = dig_q[sel];
  end

  bcd7seg_dec u_dec (
    .digit_i (dig_sel),
    .seg_o   (dec_seg)
  );

`ifdef BCD7SEG_LZB_EN
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_run;

  // Walk down from the top digit: a digit is blank while it and every digit
  // above it are zero. Digit 0 always shows.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (dig_q[k] == 4'd0);
      blank_mask[k] = zero_run;
    end
    blank_sel = blank_mask[sel];
  end
`else
  assign blank_sel = 1'b0;
`endif

  always_comb begin
    seg_d = (blank_sel ? SEG_BLANK : dec_seg) ^ SEG_XOR;
    an_d  = (5'b00001 << sel) ^ AN_XOR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q <= '0;
      idx_q <= 3'd0;
      req_q <= 1'b0;
      seg_q <= SEG_XOR;
      an_q  <= AN_XOR;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      req_q <= req_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign req = req_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd7seg_scan5.sv
// tb_bcd7seg_scan5
// Self-checking bench for bcd7seg_scan5 (DIV=3, active-low segments and
// enables). The reference model works from the cycle count since reset
// release: slot = (n mod 5*DIV)/DIV, request on the last cycle of a frame.
// Honours BCD7SEG_LZB_EN the same way the design does.
module tb_bcd7seg_scan5;

  localparam int DIV   = 3;
  localparam int FRAME = 5 * DIV;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       load = 1'b0;
  logic       conv_busy = 1'b0;
  logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;
  logic       req;
  logic [6:0] seg;
  logic [4:0] an;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [3:0] dig_m [5];

  bcd7seg_scan5 #(.DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .load(load),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
    .conv_busy(conv_busy), .req(req), .seg(seg), .an(an)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Active-high gfedcba table.
  function automatic logic [6:0] ref_pat(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    return t[d];
  endfunction

  function automatic logic [6:0] exp_seg_for(input int slot);
    logic blank;
    blank = 1'b0;
`ifdef BCD7SEG_LZB_EN
    if (slot >= 1) begin
      blank = 1'b1;
      for (int j = slot; j < 5; j++) if (dig_m[j] != 4'd0) blank = 1'b0;
    end
`endif
    return blank ? 7'h7F : ~ref_pat(dig_m[slot]);
  endfunction

  // One clock: predict from pre-edge state, advance the model, check at +1.
  task automatic step();
    int         slot;
    logic       exp_req;
    logic [6:0] exp_seg;
    logic [4:0] exp_an;
    slot    = (n % FRAME) / DIV;
    exp_req = !conv_busy && ((n % FRAME) == FRAME - 1);
    exp_seg = exp_seg_for(slot);
    exp_an  = 5'h1F ^ (5'd1 << slot);
    @(posedge CLK);
    if (load) begin
      dig_m[0] = bcd0; dig_m[1] = bcd1; dig_m[2] = bcd2; dig_m[3] = bcd3; dig_m[4] = bcd4;
    end
    n++;
    #1;
    check("seg", {25'd0, seg}, {25'd0, exp_seg});
    check("an",  {27'd0, an},  {27'd0, exp_an});
    check("req", {31'd0, req}, {31'd0, exp_req});
  endtask

  task automatic load_value(input logic [19:0] v);
    {bcd4, bcd3, bcd2, bcd1, bcd0} = v;
    load = 1'b1;
    $display("load %05h at cycle %0d", v, n);
    step();
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check({tag, "_an"},  {27'd0, an},  32'h1F);
    check({tag, "_req"}, {31'd0, req}, 32'h0);
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 5; k++) dig_m[k] = 4'd0;
  endtask

  initial begin
    model_reset();
    // Power-on reset, checked between edges and after clocking in reset.
    #12;
    check_reset_outputs("por");
    @(posedge CLK); #1;
    check_reset_outputs("por_clk");
    RST = 1'b0;
    model_reset();

    // First frame with everything zero; first edge must select digit 0.
    for (int i = 0; i < FRAME + 2; i++) step();

    // Decode sweep, then an invalid code on digit 0.
    load_value(20'h43210);
    for (int i = 0; i < 2 * FRAME; i++) step();
    load_value(20'h98765);
    for (int i = 0; i < 2 * FRAME; i++) step();
    load_value(20'hFEDCA);
    for (int i = 0; i < FRAME; i++) step();

    // Load coincident with a tick edge.
    while ((n % DIV) != DIV - 1) step();
    load_value(20'h12345);
    for (int i = 0; i < FRAME; i++) step();

    // Busy through frame end suppresses the request for those frames.
    conv_busy = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();
    conv_busy = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Leading-zero cases.
    load_value(20'h00042);
    for (int i = 0; i < FRAME + 1; i++) step();
    load_value(20'h00000);
    for (int i = 0; i < FRAME + 1; i++) step();

    // Randomized loads and busy.
    for (int i = 0; i < 400; i++) begin
      conv_busy = ($urandom % 3) == 0;
      if (($urandom % 6) == 0) begin
        logic [19:0] v;
        v = 20'($urandom);
        case ($urandom % 4)
          0: v[19:8]  = '0;
          1: v[19:16] = '0;
          default: ;
        endcase
        load_value(v);
      end else begin
        step();
      end
    end

    // Asynchronous reset mid-frame.
    conv_busy = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK); #1;
    check_reset_outputs("async_rst_clk");
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME + 2; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
